// File: rtl/load_store_buffer.sv
// In-order load/store queue: snoops the CDB for operands, runs loads
// speculatively, runs stores after commit, and broadcasts load results.
module load_store_buffer #(
    parameter int LSB_SIZE_LOG = 3,
    parameter int ROB_W        = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             rdy,
    input  logic             issue_valid,
    input  logic             issue_is_store,
    input  logic [2:0]       issue_funct3,
    input  logic [31:0]      issue_val1,
    input  logic             issue_has_dep1,
    input  logic [ROB_W-1:0] issue_dep1,
    input  logic [31:0]      issue_val2,
    input  logic             issue_has_dep2,
    input  logic [ROB_W-1:0] issue_dep2,
    input  logic [31:0]      issue_imm,
    input  logic [ROB_W-1:0] issue_rob_index,
    output logic             lsb_full,
    input  logic             alu_valid,
    input  logic [31:0]      alu_res,
    input  logic [ROB_W-1:0] alu_rob_index,
    input  logic             commit_store_valid,
    input  logic [ROB_W-1:0] commit_rob_index,
    input  logic [ROB_W-1:0] rob_head_index,
    input  logic             flush,
    output logic             mem_req_valid,
    output logic             mem_req_wr,
    output logic [31:0]      mem_req_addr,
    output logic [1:0]       mem_req_len,
    output logic [31:0]      mem_req_data,
    input  logic             mem_done,
    input  logic [31:0]      mem_rdata,
    output logic             out_valid,
    output logic [31:0]      out_value,
    output logic [ROB_W-1:0] out_rob_index
);

    localparam int DEPTH = 1 << LSB_SIZE_LOG;
    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_WAIT = 1'b1;
    localparam logic [LSB_SIZE_LOG-1:0] PTR_ONE = 1;
    localparam logic [LSB_SIZE_LOG:0] CNT_ONE = 1;
    localparam logic [LSB_SIZE_LOG:0] CNT_FULL = (LSB_SIZE_LOG+1)'(DEPTH - 1);

    typedef struct packed {
        logic             valid;
        logic             is_store;
        logic [2:0]       funct3;
        logic [31:0]      val1;
        logic             has_dep1;
        logic [ROB_W-1:0] dep1;
        logic [31:0]      val2;
        logic             has_dep2;
        logic [ROB_W-1:0] dep2;
        logic [31:0]      imm;
        logic [ROB_W-1:0] rob;
        logic             committed;
        logic             reported;
    } entry_t;

    entry_t ent_q [DEPTH];
    entry_t ent_d [DEPTH];
    logic [LSB_SIZE_LOG-1:0] head_q, head_d, tail_q, tail_d, idx;
    logic [LSB_SIZE_LOG:0]   count_q, count_d, keep;
    logic [0:0]              state_q, state_d;
    logic                    discard_q, discard_d;
    logic                    req_valid_q, req_valid_d, req_wr_q, req_wr_d;
    logic [31:0]             req_addr_q, req_addr_d, req_data_q, req_data_d;
    logic [1:0]              req_len_q, req_len_d;
    logic                    out_valid_q, out_valid_d;
    logic [31:0]             out_value_q, out_value_d;
    logic [ROB_W-1:0]        out_rob_q, out_rob_d;
    entry_t                  hd, nw;
    logic [31:0]             hd_addr;
    logic                    hd_io, hd_ready, pop, push, run, start;

    function automatic logic [31:0] load_ext(input logic [2:0] f3,
                                             input logic [31:0] r);
        case (f3)
            3'b000:  load_ext = {{24{r[7]}}, r[7:0]};
            3'b001:  load_ext = {{16{r[15]}}, r[15:0]};
            3'b100:  load_ext = {24'b0, r[7:0]};
            3'b101:  load_ext = {16'b0, r[15:0]};
            default: load_ext = r;
        endcase
    endfunction

    function automatic logic [31:0] store_data(input logic [1:0] len,
                                               input logic [31:0] v);
        case (len)
            2'b00:   store_data = {24'b0, v[7:0]};
            2'b01:   store_data = {16'b0, v[15:0]};
            default: store_data = v;
        endcase
    endfunction

    assign lsb_full      = (count_q >= CNT_FULL);
    assign mem_req_valid = req_valid_q;
    assign mem_req_wr    = req_wr_q;
    assign mem_req_addr  = req_addr_q;
    assign mem_req_len   = req_len_q;
    assign mem_req_data  = req_data_q;
    assign out_valid     = out_valid_q;
    assign out_value     = out_value_q;
    assign out_rob_index = out_rob_q;

    // Next-state: CDB snoop, commit marking, flush, head FSM and issue.
    always_comb begin
        ent_d       = ent_q;
        head_d      = head_q;
        tail_d      = tail_q;
        count_d     = count_q;
        state_d     = state_q;
        discard_d   = discard_q;
        req_valid_d = req_valid_q;
        req_wr_d    = req_wr_q;
        req_addr_d  = req_addr_q;
        req_len_d   = req_len_q;
        req_data_d  = req_data_q;
        out_valid_d = 1'b0;
        out_value_d = out_value_q;
        out_rob_d   = out_rob_q;
        pop         = 1'b0;
        push        = 1'b0;
        start       = 1'b0;
        run         = 1'b1;
        keep        = '0;
        idx         = '0;
        nw          = '0;
        hd          = ent_q[head_q];
        hd_addr     = hd.val1 + hd.imm;
        hd_io       = (hd_addr[17:16] == 2'b11);
        hd_ready    = hd.valid && !hd.has_dep1 &&
                      (!hd.is_store || !hd.has_dep2);

        for (int i = 0; i < DEPTH; i++) begin
            if (ent_q[i].valid) begin
                if (ent_q[i].has_dep1) begin
                    if (alu_valid && alu_rob_index == ent_q[i].dep1) begin
                        ent_d[i].val1     = alu_res;
                        ent_d[i].has_dep1 = 1'b0;
                    end else if (out_valid_q &&
                                 out_rob_q == ent_q[i].dep1) begin
                        ent_d[i].val1     = out_value_q;
                        ent_d[i].has_dep1 = 1'b0;
                    end
                end
                if (ent_q[i].has_dep2) begin
                    if (alu_valid && alu_rob_index == ent_q[i].dep2) begin
                        ent_d[i].val2     = alu_res;
                        ent_d[i].has_dep2 = 1'b0;
                    end else if (out_valid_q &&
                                 out_rob_q == ent_q[i].dep2) begin
                        ent_d[i].val2     = out_value_q;
                        ent_d[i].has_dep2 = 1'b0;
                    end
                end
                if (commit_store_valid && ent_q[i].is_store &&
                    ent_q[i].rob == commit_rob_index) begin
                    ent_d[i].committed = 1'b1;
                end
            end
        end

        if (flush) begin
            // Keep only the committed-store prefix starting at head.
            for (int i = 0; i < DEPTH; i++) begin
                idx = head_q + i[LSB_SIZE_LOG-1:0];
                if (run && ent_q[idx].valid && ent_q[idx].committed) begin
                    keep = keep + CNT_ONE;
                end else begin
                    run              = 1'b0;
                    ent_d[idx].valid = 1'b0;
                end
            end
            tail_d = head_q + keep[LSB_SIZE_LOG-1:0];
            if (state_q == S_WAIT && mem_done) begin
                req_valid_d = 1'b0;
                state_d     = S_IDLE;
                discard_d   = 1'b0;
                if (!discard_q && hd.committed) begin
                    ent_d[head_q].valid = 1'b0;
                    head_d  = head_q + PTR_ONE;
                    count_d = keep - CNT_ONE;
                end else begin
                    count_d = keep;
                end
            end else begin
                count_d = keep;
                if (state_q == S_WAIT && !hd.committed) begin
                    discard_d = 1'b1;
                end
            end
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (hd_ready) begin
                        if (!hd.is_store) begin
                            start = !hd_io || (rob_head_index == hd.rob);
                        end else if (!hd.reported) begin
                            out_valid_d = 1'b1;
                            out_value_d = '0;
                            out_rob_d   = hd.rob;
                            ent_d[head_q].reported = 1'b1;
                        end else if (hd.committed) begin
                            start = 1'b1;
                        end
                    end
                end
                S_WAIT: begin
                    if (mem_done) begin
                        req_valid_d = 1'b0;
                        state_d     = S_IDLE;
                        if (discard_q) begin
                            discard_d = 1'b0;
                        end else begin
                            pop = 1'b1;
                            if (!hd.is_store) begin
                                out_valid_d = 1'b1;
                                out_value_d = load_ext(hd.funct3, mem_rdata);
                                out_rob_d   = hd.rob;
                            end
                        end
                    end
                end
                default: ;
            endcase

            if (start) begin
                req_valid_d = 1'b1;
                req_wr_d    = hd.is_store;
                req_addr_d  = hd_addr;
                req_len_d   = hd.funct3[1:0];
                req_data_d  = hd.is_store ?
                              store_data(hd.funct3[1:0], hd.val2) : '0;
                state_d     = S_WAIT;
            end

            if (pop) begin
                ent_d[head_q].valid = 1'b0;
                head_d = head_q + PTR_ONE;
            end

            if (issue_valid) begin
                push        = 1'b1;
                nw.valid    = 1'b1;
                nw.is_store = issue_is_store;
                nw.funct3   = issue_funct3;
                nw.imm      = issue_imm;
                nw.rob      = issue_rob_index;
                nw.val1     = issue_val1;
                nw.has_dep1 = issue_has_dep1;
                nw.dep1     = issue_dep1;
                nw.val2     = issue_val2;
                nw.has_dep2 = issue_has_dep2;
                nw.dep2     = issue_dep2;
                if (issue_has_dep1) begin
                    if (alu_valid && alu_rob_index == issue_dep1) begin
                        nw.val1 = alu_res;
                        nw.has_dep1 = 1'b0;
                    end else if (out_valid_q && out_rob_q == issue_dep1) begin
                        nw.val1 = out_value_q;
                        nw.has_dep1 = 1'b0;
                    end
                end
                if (issue_has_dep2) begin
                    if (alu_valid && alu_rob_index == issue_dep2) begin
                        nw.val2 = alu_res;
                        nw.has_dep2 = 1'b0;
                    end else if (out_valid_q && out_rob_q == issue_dep2) begin
                        nw.val2 = out_value_q;
                        nw.has_dep2 = 1'b0;
                    end
                end
                ent_d[tail_q] = nw;
                tail_d = tail_q + PTR_ONE;
            end

            if (push && !pop) begin
                count_d = count_q + CNT_ONE;
            end else if (!push && pop) begin
                count_d = count_q - CNT_ONE;
            end
        end
    end

    // State registers: reset wins, rdy low freezes everything.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                ent_q[i] <= '0;
            end
            head_q      <= '0;
            tail_q      <= '0;
            count_q     <= '0;
            state_q     <= S_IDLE;
            discard_q   <= 1'b0;
            req_valid_q <= 1'b0;
            req_wr_q    <= 1'b0;
            req_addr_q  <= '0;
            req_len_q   <= '0;
            req_data_q  <= '0;
            out_valid_q <= 1'b0;
            out_value_q <= '0;
            out_rob_q   <= '0;
        end else if (rdy) begin
            ent_q       <= ent_d;
            head_q      <= head_d;
            tail_q      <= tail_d;
            count_q     <= count_d;
            state_q     <= state_d;
            discard_q   <= discard_d;
            req_valid_q <= req_valid_d;
            req_wr_q    <= req_wr_d;
            req_addr_q  <= req_addr_d;
            req_len_q   <= req_len_d;
            req_data_q  <= req_data_d;
            out_valid_q <= out_valid_d;
            out_value_q <= out_value_d;
            out_rob_q   <= out_rob_d;
        end
    end

endmodule

// File: tb/tb_load_store_buffer.sv
// Directed bench for load_store_buffer: loads, sign extension, store
// dependency/commit, flush, fill/wrap and I/O ordering.
module tb_load_store_buffer;

    logic        clk = 1'b0;
    logic        rst, rdy;
    logic        issue_valid, issue_is_store;
    logic [2:0]  issue_funct3;
    logic [31:0] issue_val1, issue_val2, issue_imm;
    logic        issue_has_dep1, issue_has_dep2;
    logic [5:0]  issue_dep1, issue_dep2, issue_rob_index;
    logic        lsb_full;
    logic        alu_valid;
    logic [31:0] alu_res;
    logic [5:0]  alu_rob_index;
    logic        commit_store_valid;
    logic [5:0]  commit_rob_index, rob_head_index;
    logic        flush;
    logic        mem_req_valid, mem_req_wr;
    logic [31:0] mem_req_addr, mem_req_data;
    logic [1:0]  mem_req_len;
    logic        mem_done;
    logic [31:0] mem_rdata;
    logic        out_valid;
    logic [31:0] out_value;
    logic [5:0]  out_rob_index;

    int nvec = 0;
    int nerr = 0;
    int bad_bcast = 0;

    load_store_buffer dut (
        .clk(clk), .rst(rst), .rdy(rdy),
        .issue_valid(issue_valid), .issue_is_store(issue_is_store),
        .issue_funct3(issue_funct3),
        .issue_val1(issue_val1), .issue_has_dep1(issue_has_dep1),
        .issue_dep1(issue_dep1),
        .issue_val2(issue_val2), .issue_has_dep2(issue_has_dep2),
        .issue_dep2(issue_dep2),
        .issue_imm(issue_imm), .issue_rob_index(issue_rob_index),
        .lsb_full(lsb_full),
        .alu_valid(alu_valid), .alu_res(alu_res),
        .alu_rob_index(alu_rob_index),
        .commit_store_valid(commit_store_valid),
        .commit_rob_index(commit_rob_index),
        .rob_head_index(rob_head_index), .flush(flush),
        .mem_req_valid(mem_req_valid), .mem_req_wr(mem_req_wr),
        .mem_req_addr(mem_req_addr), .mem_req_len(mem_req_len),
        .mem_req_data(mem_req_data),
        .mem_done(mem_done), .mem_rdata(mem_rdata),
        .out_valid(out_valid), .out_value(out_value),
        .out_rob_index(out_rob_index)
    );

    always #5 clk = ~clk;

    // Broadcasts from flushed loads must never appear.
    always @(negedge clk) begin
        if (out_valid && (out_rob_index inside {6'd12, 6'd13, 6'd14, 6'd20}))
            bad_bcast++;
    end

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic issue(input logic st, input logic [2:0] f3,
                         input logic [31:0] v1, input logic hd1,
                         input logic [5:0] d1, input logic [31:0] v2,
                         input logic [31:0] imm, input logic [5:0] rob);
        issue_valid     = 1'b1;
        issue_is_store  = st;
        issue_funct3    = f3;
        issue_val1      = v1;
        issue_has_dep1  = hd1;
        issue_dep1      = d1;
        issue_val2      = v2;
        issue_has_dep2  = 1'b0;
        issue_dep2      = '0;
        issue_imm       = imm;
        issue_rob_index = rob;
        tick();
        issue_valid     = 1'b0;
        issue_has_dep1  = 1'b0;
    endtask

    task automatic expect_req(input string tag, input logic wr,
                              input logic [31:0] addr, input logic [1:0] len,
                              input logic [31:0] data);
        int n = 0;
        while (!mem_req_valid && n < 20) begin
            tick();
            n++;
        end
        chk({tag, ".valid"}, {31'b0, mem_req_valid}, 32'd1);
        chk({tag, ".wr"}, {31'b0, mem_req_wr}, {31'b0, wr});
        chk({tag, ".addr"}, mem_req_addr, addr);
        chk({tag, ".len"}, {30'b0, mem_req_len}, {30'b0, len});
        if (wr) chk({tag, ".data"}, mem_req_data, data);
    endtask

    task automatic respond(input logic [31:0] rd);
        mem_done  = 1'b1;
        mem_rdata = rd;
        tick();
        mem_done  = 1'b0;
    endtask

    task automatic do_load(input string tag, input logic [2:0] f3,
                           input logic [31:0] v1, input logic [31:0] imm,
                           input logic [5:0] rob, input logic [31:0] addr,
                           input logic [31:0] rd, input logic [31:0] ev);
        issue(1'b0, f3, v1, 1'b0, 6'd0, 32'd0, imm, rob);
        expect_req(tag, 1'b0, addr, f3[1:0], 32'd0);
        respond(rd);
        chk({tag, ".out_valid"}, {31'b0, out_valid}, 32'd1);
        chk({tag, ".out_value"}, out_value, ev);
        chk({tag, ".out_rob"}, {26'b0, out_rob_index}, {26'b0, rob});
        chk({tag, ".req_drop"}, {31'b0, mem_req_valid}, 32'd0);
        tick();
        chk({tag, ".pulse"}, {31'b0, out_valid}, 32'd0);
    endtask

    initial begin
        int n;
        rst = 1'b1; rdy = 1'b1;
        issue_valid = 0; issue_is_store = 0; issue_funct3 = 0;
        issue_val1 = 0; issue_val2 = 0; issue_imm = 0;
        issue_has_dep1 = 0; issue_has_dep2 = 0;
        issue_dep1 = 0; issue_dep2 = 0; issue_rob_index = 0;
        alu_valid = 0; alu_res = 0; alu_rob_index = 0;
        commit_store_valid = 0; commit_rob_index = 0;
        rob_head_index = 0; flush = 0; mem_done = 0; mem_rdata = 0;
        tick(); tick();
        rst = 1'b0;

        chk("rst.req_valid", {31'b0, mem_req_valid}, 32'd0);
        chk("rst.out_valid", {31'b0, out_valid}, 32'd0);
        chk("rst.lsb_full", {31'b0, lsb_full}, 32'd0);
        chk("rst.req_addr", mem_req_addr, 32'd0);
        chk("rst.out_value", out_value, 32'd0);
        chk("rst.count", {28'b0, dut.count_q}, 32'd0);

        // LW with a held request to check stability.
        issue(1'b0, 3'b010, 32'hF0, 1'b0, 6'd0, 32'd0, 32'h10, 6'd1);
        expect_req("lw", 1'b0, 32'h100, 2'd2, 32'd0);
        tick(); tick();
        chk("lw.hold_valid", {31'b0, mem_req_valid}, 32'd1);
        chk("lw.hold_addr", mem_req_addr, 32'h100);
        chk("lw.no_early_out", {31'b0, out_valid}, 32'd0);
        respond(32'h12345678);
        chk("lw.out_valid", {31'b0, out_valid}, 32'd1);
        chk("lw.out_value", out_value, 32'h12345678);
        chk("lw.out_rob", {26'b0, out_rob_index}, 32'd1);
        chk("lw.req_drop", {31'b0, mem_req_valid}, 32'd0);
        tick();
        chk("lw.pulse", {31'b0, out_valid}, 32'd0);

        do_load("lb", 3'b000, 32'h40, 32'd0, 6'd2, 32'h40,
                32'h00000080, 32'hFFFFFF80);
        do_load("lbu", 3'b100, 32'h40, 32'd0, 6'd3, 32'h40,
                32'h00000080, 32'h00000080);
        do_load("lh", 3'b001, 32'h44, 32'd0, 6'd4, 32'h44,
                32'h00008001, 32'hFFFF8001);

        // Store waiting on ROB tag 5 for its base address.
        issue(1'b1, 3'b010, 32'd0, 1'b1, 6'd5, 32'hDEADBEEF, 32'd0, 6'd6);
        tick(); tick();
        chk("st.dep_no_report", {31'b0, out_valid}, 32'd0);
        chk("st.dep_no_req", {31'b0, mem_req_valid}, 32'd0);
        alu_valid = 1'b1; alu_rob_index = 6'd5; alu_res = 32'h200;
        tick();
        alu_valid = 1'b0;
        n = 0;
        while (!out_valid && n < 10) begin
            tick();
            n++;
        end
        chk("st.report", {31'b0, out_valid}, 32'd1);
        chk("st.report_val", out_value, 32'd0);
        chk("st.report_rob", {26'b0, out_rob_index}, 32'd6);
        tick(); tick(); tick();
        chk("st.wait_commit", {31'b0, mem_req_valid}, 32'd0);
        commit_store_valid = 1'b1; commit_rob_index = 6'd6;
        tick();
        commit_store_valid = 1'b0;
        expect_req("st", 1'b1, 32'h200, 2'd2, 32'hDEADBEEF);
        respond(32'd0);
        chk("st.no_bcast", {31'b0, out_valid}, 32'd0);

        // Two committed stores, three loads, then flush.
        issue(1'b1, 3'b000, 32'h300, 1'b0, 6'd0, 32'h11, 32'd0, 6'd10);
        issue(1'b1, 3'b001, 32'h304, 1'b0, 6'd0, 32'h2222, 32'd0, 6'd11);
        issue(1'b0, 3'b010, 32'h400, 1'b0, 6'd0, 32'd0, 32'd0, 6'd12);
        issue(1'b0, 3'b010, 32'h404, 1'b0, 6'd0, 32'd0, 32'd0, 6'd13);
        issue(1'b0, 3'b010, 32'h408, 1'b0, 6'd0, 32'd0, 32'd0, 6'd14);
        commit_store_valid = 1'b1; commit_rob_index = 6'd10;
        tick();
        commit_rob_index = 6'd11;
        tick();
        commit_store_valid = 1'b0;
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("fl.count", {28'b0, dut.count_q}, 32'd2);
        expect_req("fl.stA", 1'b1, 32'h300, 2'd0, 32'h11);
        respond(32'd0);
        expect_req("fl.stB", 1'b1, 32'h304, 2'd1, 32'h2222);
        respond(32'd0);
        tick(); tick(); tick();
        chk("fl.no_more_req", {31'b0, mem_req_valid}, 32'd0);
        chk("fl.empty", {28'b0, dut.count_q}, 32'd0);

        // Flush while a load is outstanding: result is dropped.
        issue(1'b0, 3'b010, 32'h500, 1'b0, 6'd0, 32'd0, 32'd0, 6'd20);
        expect_req("fld", 1'b0, 32'h500, 2'd2, 32'd0);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("fld.held", {31'b0, mem_req_valid}, 32'd1);
        chk("fld.count", {28'b0, dut.count_q}, 32'd0);
        respond(32'h99);
        chk("fld.no_out", {31'b0, out_valid}, 32'd0);
        chk("fld.req_drop", {31'b0, mem_req_valid}, 32'd0);
        tick();
        chk("fld.bcast", bad_bcast, 32'd0);
        chk("fill.head", {29'b0, dut.head_q}, 32'd7);

        // Fill 7 entries behind a blocked I/O load; head wraps 7->0.
        issue(1'b0, 3'b010, 32'h30000, 1'b0, 6'd0, 32'd0, 32'd0, 6'd30);
        for (int k = 1; k <= 6; k++) begin
            chk("fill.not_full", {31'b0, lsb_full}, 32'd0);
            issue(1'b0, 3'b010, 32'h1000 + 32'(4 * k), 1'b0, 6'd0,
                  32'd0, 32'd0, 6'(30 + k));
        end
        chk("fill.full", {31'b0, lsb_full}, 32'd1);
        tick(); tick(); tick();
        chk("io.blocked", {31'b0, mem_req_valid}, 32'd0);
        rob_head_index = 6'd30;
        tick();
        chk("io.req", {31'b0, mem_req_valid}, 32'd1);
        chk("io.addr", mem_req_addr, 32'h30000);
        rdy = 1'b0;
        mem_done = 1'b1;
        mem_rdata = 32'h55;
        tick(); tick();
        chk("rdy.hold_req", {31'b0, mem_req_valid}, 32'd1);
        chk("rdy.no_out", {31'b0, out_valid}, 32'd0);
        chk("rdy.head", {29'b0, dut.head_q}, 32'd7);
        rdy = 1'b1;
        tick();
        mem_done = 1'b0;
        chk("io.out_valid", {31'b0, out_valid}, 32'd1);
        chk("io.out_value", out_value, 32'h55);
        chk("io.out_rob", {26'b0, out_rob_index}, 32'd30);
        chk("wrap.head", {29'b0, dut.head_q}, 32'd0);
        chk("wrap.not_full", {31'b0, lsb_full}, 32'd0);
        for (int k = 1; k <= 6; k++) begin
            expect_req("drain", 1'b0, 32'h1000 + 32'(4 * k), 2'd2, 32'd0);
            respond(32'hA0 + 32'(k));
            chk("drain.out_valid", {31'b0, out_valid}, 32'd1);
            chk("drain.value", out_value, 32'hA0 + 32'(k));
            chk("drain.rob", {26'b0, out_rob_index}, 32'(30 + k));
        end
        tick();
        chk("end.empty", {28'b0, dut.count_q}, 32'd0);
        chk("end.bcast", bad_bcast, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule

// File: doc/load_store_buffer.md
# load_store_buffer

In-order load/store queue for the out-of-order RISC-V core. It sits downstream of the instruction issuer, in parallel with the reservation station, and upstream of the memory controller's data port. It holds loads and stores in program order and resolves their operand dependencies by snooping the CDB. It executes loads speculatively, executes stores only after the reorder buffer commits them, and broadcasts load results back onto the CDB.

## Interface
- LSB_SIZE_LOG, 3, log2 of queue depth (8 entries)
- ROB_W, 6, ROB index width
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- rdy  in  1  global enable; low freezes all state and outputs
- issue_valid  in  1  new memory instruction this cycle
- issue_is_store  in  1  1 = SB/SH/SW, 0 = load
- issue_funct3  in  3  RISC-V funct3 (000 B, 001 H, 010 W, 100 BU, 101 HU)
- issue_val1 / issue_has_dep1 / issue_dep1  in  32/1/ROB_W  base-address operand or its ROB tag
- issue_val2 / issue_has_dep2 / issue_dep2  in  32/1/ROB_W  store-data operand or its ROB tag (ignored for loads)
- issue_imm  in  32  sign-extended offset
- issue_rob_index  in  ROB_W  destination ROB entry
- lsb_full  out  1  fewer than 2 free entries
- alu_valid / alu_res / alu_rob_index  in  1/32/ROB_W  ALU CDB broadcast
- commit_store_valid / commit_rob_index  in  1/ROB_W  ROB commits a store
- rob_head_index  in  ROB_W  index of the oldest ROB entry
- flush  in  1  mispredict; discard speculative state
- mem_req_valid  out  1  data-port request; held until done
- mem_req_wr  out  1  1 = store
- mem_req_addr  out  32  byte address
- mem_req_len  out  2  0 byte, 1 half, 2 word
- mem_req_data  out  32  store data, LSB-aligned
- mem_done / mem_rdata  in  1/32  request completion pulse and raw read data, LSB-aligned
- out_valid / out_value / out_rob_index  out  1/32/ROB_W  LSB CDB broadcast

## Operation
- Queue structure: circular queue with head, tail and count.
  - Issue writes the entry at tail.
  - If an issue dep tag equals the ROB index on alu_valid or out_valid in the same cycle, the broadcast value is captured directly and the entry is marked dep-free.
- CDB snoop: every cycle, every valid entry with has_dep and a matching tag on the ALU CDB or the LSB CDB takes the value and clears has_dep.
- Address: val1 + imm, mod 2^32, computed when the head is considered.
- FSM states: IDLE, WAIT_MEM.
- IDLE considers only the head entry, with no dependencies left:
  - Load, address not I/O (addr[17:16] != 2'b11): issue the request and go to WAIT_MEM.
  - Load, I/O address: wait until rob_head_index == entry rob index, then issue.
  - Store, not yet reported: emit out_valid with value 0 and the entry's rob index once, then set reported.
  - Store, marked committed: issue the write and go to WAIT_MEM.
- Commit tracking: commit_store_valid sets committed on the entry whose rob index matches.
- WAIT_MEM: on mem_done, pop the head and return to IDLE.
  - For a load, register the result onto out_valid/out_value next cycle.
  - LB/LH sign-extend mem_rdata[7:0] / [15:0]; LBU/LHU zero-extend; LW passes 32 bits.
- Flush behaviour:
  - Drop every entry not marked committed; committed stores form a prefix from head and are kept.
  - Set tail = head + committed count.
  - An outstanding load request runs to mem_done, but its result is discarded and out_valid is not raised.
  - An outstanding committed store completes normally.
  - Issue in the flush cycle is ignored.
- Pop and issue in the same cycle: count is unchanged.

## Timing
- Reset values: head = tail = count = 0, all entries invalid, FSM in IDLE, every output 0.
- rst has priority over flush, which has priority over normal operation.
- rdy low: no state changes, outputs hold.
- Issue-to-request latency: an entry issued at cycle t with no deps reaches the head no earlier than t+1; mem_req_valid rises at t+1 at the earliest.
- Request handshake: mem_req_* stays stable while mem_req_valid is high, until the mem_done cycle; mem_req_valid drops the cycle after mem_done.
- Load result: out_valid is a single-cycle pulse, one cycle after mem_done.
- lsb_full is combinational on count: asserted when count >= 2^LSB_SIZE_LOG - 1.
- Wrap-around: head and tail wrap modulo 2^LSB_SIZE_LOG.

## Test plan
- LW from 0x100 (val1=0xF0, imm=0x10) with no deps, memory returns 0x12345678: mem_req_addr=0x100, len=2; out_valid one cycle after mem_done with 0x12345678.
- LB from a byte holding 0x80: out_value=0xFFFFFF80. LBU from the same byte: 0x00000080.
- Store with dep1 tag 5; ALU broadcasts tag 5 value 0x200: LSB reports ready; after commit_store_valid, write to 0x200 with the correct data and len.
- Two committed stores followed by three loads, flush asserted: both stores still write in order; no load out_valid; count = 2 after the flush cycle.
- Fill 7 entries: lsb_full=1. Drain through the head index wrapping 7->0: order is preserved.
- Load from 0x30000 while rob_head_index differs: no request. Once rob_head_index matches, request issued the same cycle the match is seen in IDLE.
